tempsens_multich_ctrl: RTL and testbench
========================================

// Module: tempsens_multich_ctrl
// PURPOSE
//  Multi-channel readout controller for ring-oscillator temperature sensors in the tt_um tempsens top.
//  Enables one sensor oscillator at a time and counts its edges over a fixed gate window.
//  Averages 2^AVG_LOG2 samples per channel and stores one result per channel.
//  Flags over-temperature per channel with hysteresis; results are read back through a channel-select mux.
// PARAMETERS
//  NCH        4   number of sensor channels (>=2)
//  CNT_W      12  edge-counter/result width
//  GATE_LOG2  6   gate window = 2^GATE_LOG2 clk cycles
//  AVG_LOG2   2   samples averaged per channel = 2^AVG_LOG2
//  SETTLE_CYC 4   cycles the oscillator runs before counting starts (>=1)
//  HYST       4   alarm release hysteresis, result LSBs
//  SEL_W      $clog2(NCH) (derived)
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       asynchronous, active-low reset
//  ena        in   1       design enable; low aborts any sweep
//  start      in   1       one-cycle sweep request
//  cont_mode  in   1       1 = restart sweep automatically after done
//  osc_pulse  in   NCH     one-cycle edge pulse per oscillator, already synchronised to clk
//  thresh     in   CNT_W   alarm threshold
//  rd_sel     in   SEL_W   readback channel select
//  osc_en     out  NCH     one-hot oscillator enable
//  rd_data    out  CNT_W   averaged result of channel rd_sel
//  rd_valid   out  1       channel rd_sel has a result since reset
//  alarm      out  NCH     per-channel over-temperature flag
//  busy       out  1       sweep in progress
//  done       out  1       one-cycle pulse at end of sweep
// BEHAVIOUR
//  - Reset: all outputs 0, all result regs 0, valid bits 0, FSM IDLE, channel 0.
//  - FSM states:
//    - IDLE: start & ena -> SETTLE on channel 0; busy rises on the next cycle.
//    - SETTLE: runs SETTLE_CYC cycles, then -> GATE.
//    - GATE: runs 2^GATE_LOG2 cycles, then -> STORE.
//    - STORE: 1 cycle, then -> SETTLE; on the last sample of the last channel -> DONE.
//    - DONE: 1 cycle; done=1, then -> IDLE, or -> SETTLE on channel 0 if cont_mode.
//  - osc_en[ch]=1 in SETTLE/GATE/STORE only; busy=1 in all states except IDLE.
//  - GATE: counter increments on osc_pulse[ch] only; pulses on other channels are ignored.
//  - Counter saturates at 2^CNT_W-1 and clears on entry to GATE.
//  - STORE: the count is added into an accumulator (CNT_W+AVG_LOG2 bits, never overflows).
//    - After sample 2^AVG_LOG2-1, result[ch] = acc>>AVG_LOG2 (truncated) and valid[ch]=1.
//    - The accumulator and sample counter then clear and ch advances by 1.
//  - Timing: cycles per sample = SETTLE_CYC+2^GATE_LOG2+1.
//    - Sweep = NCH*2^AVG_LOG2*(that) cycles + 1 DONE cycle.
//  - Alarm is updated only when result[ch] is written:
//    - set if result >= thresh;
//    - clear if result < max(thresh-HYST,0);
//    - otherwise hold.
//  - start while busy: ignored. start with ena=0: ignored.
//  - ena low in any non-IDLE state: next edge -> IDLE, osc_en=0, busy=0, no done.
//    - Accumulator, counter and channel clear; results, valid and alarm are retained.
//  - rd_data/rd_valid: combinational mux of registered state.
//    - rd_sel >= NCH reads rd_data=0, rd_valid=0.
//    - A result write is visible on rd_data the cycle after STORE.
// STRUCTURE
//  - tempsens_pkg: FSM state enum (IDLE, SETTLE, GATE, STORE, DONE) and a clog2-safe width helper.
//  - Sub-module tempsens_gate_counter (CNT_W):
//    - inputs clear, count_en, pulse; output count; saturating.
//    - Instantiated once, with a muxed pulse input.
// TESTING (NCH=4, CNT_W=12, GATE_LOG2=6, AVG_LOG2=2, SETTLE_CYC=4, HYST=4)
//  1 Reset mid-sweep -> all outputs 0 immediately.
//    - Then rd_sel=0 gives rd_data=0, rd_valid=0.
//  2 start; ch0 pulse every 2nd cycle, ch1 every 4th, ch2-3 idle.
//    - done exactly 1105 cycles after start.
//    - rd_data ch0=32, ch1=16, ch2=ch3=0; all rd_valid=1.
//  3 GATE_LOG2=13 build, ch0 pulse every cycle -> ch0 rd_data=4095 (saturation); other channels unaffected.
//  4 thresh=30, successive sweeps with ch0 at 32/28/25 counts:
//    - alarm[0] 1 after sweep 1; stays 1 after sweep 2; 0 after sweep 3.
//  5 ena=0 during GATE of ch2:
//    - next cycle busy=0, osc_en=0, no done pulse.
//    - ch0/ch1 results unchanged; restart completes normally.
//  6 cont_mode=1: second sweep starts the cycle after done without start.
//    - start pulse during busy has no effect.
//    - rd_sel=5 (SEL_W widened in bench) -> rd_data=0, rd_valid=0.

Source files
------------

// File: rtl/tempsens_pkg.sv
// -----------------------------------------------------------------------------
// tempsens_pkg
// Shared types and helpers for the multi-channel temperature sensor readout.
//   state_e    : sweep FSM states
//   clog2_safe : $clog2 that never returns 0, so it can size a vector directly
// -----------------------------------------------------------------------------
package tempsens_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_GATE,
        ST_STORE,
        ST_DONE
    } state_e;

    // Width able to index n items; at least 1 bit even for n <= 2.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tempsens_multich_ctrl_if.sv
// -----------------------------------------------------------------------------
// tempsens_multich_ctrl_if
// Result readback bus of the temperature sensor controller.
//   rd_sel   : channel select (driven by the reader)
//   rd_data  : averaged result of the selected channel
//   rd_valid : selected channel holds a result since reset
// Modports: master = reader, slave = controller.
// -----------------------------------------------------------------------------
interface tempsens_multich_ctrl_if #(
    parameter int CNT_W = 12,
    parameter int SEL_W = 2
);
    logic [SEL_W-1:0] rd_sel;
    logic [CNT_W-1:0] rd_data;
    logic             rd_valid;

    modport master (output rd_sel, input rd_data, input rd_valid);
    modport slave  (input rd_sel, output rd_data, output rd_valid);
endinterface

// File: rtl/tempsens_gate_counter.sv
// -----------------------------------------------------------------------------
// tempsens_gate_counter
// Saturating edge counter for one gate window.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear (wins over counting)
//   count_en   : counting window open
//   pulse      : one-cycle edge pulse of the selected oscillator
//   count      : edges seen since clear, held at all-ones once reached
// -----------------------------------------------------------------------------
module tempsens_gate_counter #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             count_en,
    input  logic             pulse,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && pulse && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tempsens_multich_ctrl.sv
// -----------------------------------------------------------------------------
// tempsens_multich_ctrl
// Sweeps NCH ring-oscillator sensors one at a time: settle, count edges over a
// 2^GATE_LOG2 cycle gate, average 2^AVG_LOG2 samples, store per-channel result
// and update a hysteretic over-temperature flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : enable; low aborts a sweep (results/valid/alarm retained)
//   start      : one-cycle sweep request (ignored while busy or ena=0)
//   cont_mode  : restart sweep automatically after done
//   osc_pulse  : per-oscillator edge pulses, synchronous to clk
//   thresh     : alarm threshold
//   rd         : readback bus (slave)
//   osc_en     : one-hot oscillator enable
//   alarm      : per-channel over-temperature flag
//   busy, done : sweep in progress / one-cycle end-of-sweep pulse
// -----------------------------------------------------------------------------
module tempsens_multich_ctrl
    import tempsens_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int CNT_W      = 12,
    parameter int GATE_LOG2  = 6,
    parameter int AVG_LOG2   = 2,
    parameter int SETTLE_CYC = 4,
    parameter int HYST       = 4,
    parameter int SEL_W      = clog2_safe(NCH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   start,
    input  logic                   cont_mode,
    input  logic [NCH-1:0]         osc_pulse,
    input  logic [CNT_W-1:0]       thresh,
    tempsens_multich_ctrl_if.slave rd,
    output logic [NCH-1:0]         osc_en,
    output logic [NCH-1:0]         alarm,
    output logic                   busy,
    output logic                   done
);

    localparam int CH_W     = clog2_safe(NCH);
    localparam int SMP_W    = clog2_safe(1 << AVG_LOG2);
    localparam int ACC_W    = CNT_W + AVG_LOG2;
    localparam int GATE_CYC = 1 << GATE_LOG2;
    localparam int TMR_W    = clog2_safe((GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC);

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q;
    logic [SMP_W-1:0]   smp_q;
    logic [CH_W-1:0]    ch_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   result_q [NCH];
    logic [NCH-1:0]     valid_q;

    logic               settle_end, gate_end, last_smp, last_ch, store_now;
    logic [CNT_W-1:0]   count;
    logic [ACC_W-1:0]   acc_sum;
    logic [CNT_W-1:0]   new_res, alarm_lo;

    assign settle_end = (state_q == ST_SETTLE) && (tmr_q == TMR_W'(SETTLE_CYC - 1));
    assign gate_end   = (state_q == ST_GATE)   && (tmr_q == TMR_W'(GATE_CYC - 1));
    assign last_smp   = (smp_q == SMP_W'((1 << AVG_LOG2) - 1));
    assign last_ch    = (ch_q == CH_W'(NCH - 1));
    assign store_now  = ena && (state_q == ST_STORE);
    assign acc_sum    = acc_q + ACC_W'(count);
    assign new_res    = CNT_W'(acc_sum >> AVG_LOG2);
    assign alarm_lo   = (thresh > CNT_W'(HYST)) ? (thresh - CNT_W'(HYST)) : '0;

    // Counter is cleared on GATE entry and on abort; only the active channel counts.
    tempsens_gate_counter #(.CNT_W(CNT_W)) u_gate_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (!ena || settle_end),
        .count_en (state_q == ST_GATE),
        .pulse    (osc_pulse[ch_q]),
        .count    (count)
    );

    // NOTE: every combinational output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (!ena) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:   if (start) state_d = ST_SETTLE;
                ST_SETTLE: if (settle_end) state_d = ST_GATE;
                ST_GATE:   if (gate_end) state_d = ST_STORE;
                ST_STORE:  state_d = (last_smp && last_ch) ? ST_DONE : ST_SETTLE;
                ST_DONE:   state_d = cont_mode ? ST_SETTLE : ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        osc_en = '0;
        if (state_q inside {ST_SETTLE, ST_GATE, ST_STORE}) osc_en[ch_q] = 1'b1;
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            // Phase timer restarts on every state change.
            if (state_d != state_q) tmr_q <= '0;
            else if (state_q inside {ST_SETTLE, ST_GATE}) tmr_q <= tmr_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            smp_q <= '0;
            ch_q  <= '0;
        end else if (!ena) begin
            acc_q <= '0;
            smp_q <= '0;
            ch_q  <= '0;
        end else if (state_q == ST_STORE) begin
            if (last_smp) begin
                acc_q <= '0;
                smp_q <= '0;
                ch_q  <= last_ch ? '0 : ch_q + CH_W'(1);
            end else begin
                acc_q <= acc_sum;
                smp_q <= smp_q + SMP_W'(1);
            end
        end
    end

    // NOTE: the per-channel result array is reset because readback of a
    // never-written channel must return 0; it is a handful of flops, not a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) result_q[i] <= '0;
            valid_q <= '0;
            alarm   <= '0;
        end else if (store_now && last_smp) begin
            result_q[ch_q] <= new_res;
            valid_q[ch_q]  <= 1'b1;
            // Set wins; clear only below thresh-HYST; otherwise hold.
            if (new_res >= thresh)        alarm[ch_q] <= 1'b1;
            else if (new_res < alarm_lo)  alarm[ch_q] <= 1'b0;
        end
    end

    always_comb begin
        rd.rd_data  = '0;
        rd.rd_valid = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (rd.rd_sel == SEL_W'(i)) begin
                rd.rd_data  = result_q[i];
                rd.rd_valid = valid_q[i];
            end
        end
    end

endmodule

// File: tb/tb_tempsens_multich_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tempsens_multich_ctrl
// Scoreboard bench: stimulus pushes the expected per-sweep readback into a
// queue; a monitor pops and compares it whenever done pulses. A second DUT
// with a long gate window exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_tempsens_multich_ctrl;

    typedef struct packed {
        logic [3:0][11:0] data;
        logic [3:0]       alarm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, ena, start, cont_mode;
    logic [3:0]  osc_pulse;
    logic [11:0] thresh;
    logic [3:0]  osc_en, alarm;
    logic        busy, done;

    logic        ena_s, start_s;
    logic [1:0]  osc_en_s, alarm_s;
    logic        busy_s, done_s;

    logic [2:0]  mon_sel, ovr_sel;
    logic        ovr_en;
    int          per [4];
    int          kb  [4];
    int          cyc;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    tempsens_multich_ctrl_if #(.CNT_W(12), .SEL_W(3)) rd_if ();
    tempsens_multich_ctrl_if #(.CNT_W(12), .SEL_W(1)) rd_s ();

    assign rd_if.rd_sel = ovr_en ? ovr_sel : mon_sel;

    tempsens_multich_ctrl #(
        .NCH(4), .CNT_W(12), .GATE_LOG2(6), .AVG_LOG2(2),
        .SETTLE_CYC(4), .HYST(4), .SEL_W(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .cont_mode(cont_mode),
        .osc_pulse(osc_pulse), .thresh(thresh), .rd(rd_if),
        .osc_en(osc_en), .alarm(alarm), .busy(busy), .done(done)
    );

    tempsens_multich_ctrl #(
        .NCH(2), .CNT_W(12), .GATE_LOG2(13), .AVG_LOG2(0),
        .SETTLE_CYC(4), .HYST(4), .SEL_W(1)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .ena(ena_s), .start(start_s), .cont_mode(1'b0),
        .osc_pulse(2'b01), .thresh(12'd4095), .rd(rd_s),
        .osc_en(osc_en_s), .alarm(alarm_s), .busy(busy_s), .done(done_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input int d0, input int d1, input int d2, input int d3,
                                    input logic [3:0] al);
        exp_t e;
        e.data[0] = 12'(d0);
        e.data[1] = 12'(d1);
        e.data[2] = 12'(d2);
        e.data[3] = 12'(d3);
        e.alarm   = al;
        return e;
    endfunction

    // Pulse generator: periodic (per != 0) or a burst of kb pulses per 64 cycles.
    // Both give an exact count in any 64-cycle gate window.
    initial begin
        osc_pulse = '0;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 4; i++)
                osc_pulse[i] = (per[i] != 0) ? ((cyc % per[i]) == 0) : ((cyc % 64) < kb[i]);
        end
    end

    // Monitor: on each done pulse, compare alarm and all channel readbacks.
    initial begin : monitor
        exp_t e;
        int   sw;
        sw = 0;
        mon_sel = '0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                sw++;
                if (exp_q.size() == 0) begin
                    check($sformatf("sweep%0d_unexpected_done", sw), 32'(done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("sweep%0d_alarm", sw), 32'(alarm), 32'(e.alarm));
                    for (int c = 0; c < 4; c++) begin
                        mon_sel = 3'(c);
                        #1;
                        check($sformatf("sweep%0d_ch%0d_data", sw, c), 32'(rd_if.rd_data), 32'(e.data[c]));
                        check($sformatf("sweep%0d_ch%0d_valid", sw, c), 32'(rd_if.rd_valid), 32'd1);
                    end
                    mon_sel = '0;
                end
            end
        end
    end

    // Counts posedges until done (start is dropped after the first edge).
    task automatic run_until_done(input string name, input int exp_n);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            start = 1'b0;
            if (done === 1'b1) seen = 1'b1;
        end
        check(name, 32'(n), 32'(exp_n));
    endtask

    task automatic sweep(input string name);
        @(negedge clk);
        start = 1'b1;
        run_until_done(name, 1105);
        repeat (2) @(posedge clk);
    endtask

    task automatic set_pat(input int p0, input int k0, input int p1, input int k1,
                           input int p2, input int k2, input int p3, input int k3);
        per[0] = p0; kb[0] = k0; per[1] = p1; kb[1] = k1;
        per[2] = p2; kb[2] = k2; per[3] = p3; kb[3] = k3;
    endtask

    task automatic read_ch(input string name, input int ch, input int exp_d, input int exp_v);
        ovr_sel = 3'(ch);
        ovr_en  = 1'b1;
        #1;
        check({name, "_data"}, 32'(rd_if.rd_data), 32'(exp_d));
        check({name, "_valid"}, 32'(rd_if.rd_valid), 32'(exp_v));
        ovr_en  = 1'b0;
    endtask

    initial begin : stimulus
        int n;
        int dn;
        bit seen;
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; cont_mode = 1'b0; thresh = 12'd4095;
        ena_s = 1'b1; start_s = 1'b0; rd_s.rd_sel = 1'b0;
        ovr_en = 1'b0; ovr_sel = '0;
        set_pat(2, 0, 4, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: reset in the middle of a sweep
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("t1_busy_before_reset", 32'(busy), 32'd1);
        check("t1_osc_en_before_reset", 32'(osc_en), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t1_busy_reset", 32'(busy), 32'd0);
        check("t1_osc_en_reset", 32'(osc_en), 32'd0);
        check("t1_done_reset", 32'(done), 32'd0);
        check("t1_alarm_reset", 32'(alarm), 32'd0);
        read_ch("t1_ch0", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 2: nominal sweep, latency and averaged counts
        exp_q.push_back(mk_exp(32, 16, 0, 0, 4'b0000));
        sweep("t2_done_latency");

        // 4: alarm hysteresis over three sweeps, thresh=30 (release below 26)
        thresh = 12'd30;
        set_pat(2, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(mk_exp(32, 0, 0, 0, 4'b0001));
        sweep("t4_sweep1_latency");
        set_pat(0, 28, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(mk_exp(28, 0, 0, 0, 4'b0001));
        sweep("t4_sweep2_latency");
        set_pat(0, 25, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(mk_exp(25, 0, 0, 0, 4'b0000));
        sweep("t4_sweep3_latency");

        // 5: abort during the gate of channel 2, then restart
        set_pat(2, 0, 0, 20, 2, 0, 0, 0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (566) @(posedge clk);
        #1;
        check("t5_busy_in_gate", 32'(busy), 32'd1);
        check("t5_osc_en_ch2", 32'(osc_en), 32'h4);
        ena = 1'b0;
        @(posedge clk);
        #1;
        check("t5_busy_after_abort", 32'(busy), 32'd0);
        check("t5_osc_en_after_abort", 32'(osc_en), 32'd0);
        dn = 0;
        for (int i = 0; i < 1200; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dn++;
        end
        check("t5_no_done", 32'(dn), 32'd0);
        read_ch("t5_ch0", 0, 32, 1);
        read_ch("t5_ch1", 1, 20, 1);
        read_ch("t5_ch2", 2, 0, 1);
        check("t5_alarm_retained", 32'(alarm), 32'h1);
        ena = 1'b1;
        exp_q.push_back(mk_exp(32, 20, 32, 0, 4'b0101));
        sweep("t5_restart_latency");

        // 6: continuous mode, start while busy, out-of-range readback
        set_pat(2, 0, 4, 0, 0, 0, 0, 10);
        cont_mode = 1'b1;
        exp_q.push_back(mk_exp(32, 16, 0, 10, 4'b0001));
        exp_q.push_back(mk_exp(32, 16, 0, 10, 4'b0001));
        @(negedge clk);
        start = 1'b1;
        run_until_done("t6_first_latency", 1105);
        @(posedge clk);
        #1;
        check("t6_busy_after_done", 32'(busy), 32'd1);
        check("t6_osc_en_restart", 32'(osc_en), 32'h1);
        start = 1'b1;
        cont_mode = 1'b0;
        run_until_done("t6_second_period", 1104);
        @(posedge clk);
        #1;
        check("t6_idle_after_second", 32'(busy), 32'd0);
        read_ch("t6_sel5", 5, 0, 0);
        read_ch("t6_ch3", 3, 10, 1);

        // 3: saturation on the long-gate instance
        @(negedge clk);
        start_s = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
            start_s = 1'b0;
            if (done_s === 1'b1) seen = 1'b1;
        end
        check("t3_done_latency", 32'(n), 32'd16395);
        rd_s.rd_sel = 1'b0;
        #1;
        check("t3_ch0_saturated", 32'(rd_s.rd_data), 32'd4095);
        check("t3_ch0_valid", 32'(rd_s.rd_valid), 32'd1);
        rd_s.rd_sel = 1'b1;
        #1;
        check("t3_ch1_data", 32'(rd_s.rd_data), 32'd0);
        check("t3_ch1_valid", 32'(rd_s.rd_valid), 32'd1);
        check("t3_alarm", 32'(alarm_s), 32'h1);

        // Reset after results exist clears valid, data and alarm.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("final_alarm_reset", 32'(alarm), 32'd0);
        read_ch("final_ch0", 0, 0, 0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
